// File: rtl/demorgan_pkg.sv
// rtl/demorgan_pkg.sv - shared constants and state type for the De Morgan sweep checker
//
// Holds the FSM state encoding and the number of stimulus vectors in a sweep.

package demorgan_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // {a,b} walks 00,01,10,11 once per pass
    localparam int NUM_VECS = 4;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        DRIVE = S_DRIVE,
        CHECK = S_CHECK,
        DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/demorgan_sweep_checker.sv
// rtl/demorgan_sweep_checker.sv - exhaustive sweep checker for a two-input NOR stage
//
// Drives every {a,b} combination PASSES times, compares the stage output
// against ~(a|b) and counts mismatches (saturating).
//
// Parameters:
//   PASSES  number of full 4-vector sweeps per run (1..255)
//   CNT_W   width of the mismatch counter
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               single-cycle run request (ignored while busy)
//   dut_c               output c of the stage under test
//   a_o, b_o            stimulus to the stage
//   busy                run in progress
//   done, pass          results held; pass means no mismatch
//   err_cnt             mismatch count of the current or last run
//   fail_vec/fail_valid first failing {a,b} of the run
//
// Build option: DEMORGAN_CHK_CAPTURE_EN enables the first-failure capture;
// without it fail_vec/fail_valid are tied to zero.

module demorgan_sweep_checker
    import demorgan_pkg::*;
#(
    parameter int PASSES = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_c,
    output logic             a_o,
    output logic             b_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       fail_vec,
    output logic             fail_valid
);

    localparam logic [1:0]       LAST_VEC  = 2'(NUM_VECS - 1);
    localparam logic [7:0]       LAST_PASS = 8'(PASSES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};

    state_t     state;
    state_t     state_nx;
    logic [1:0] vec_idx;
    logic [7:0] pass_idx;
    logic       done_q;
    logic       expected;
    logic       mismatch;
    logic       run_start;

    assign expected  = ~(a_o | b_o);
    assign mismatch  = (state == CHECK) && (dut_c != expected);
    assign run_start = ((state == IDLE) || (state == DONE)) && start;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = DRIVE;
            DRIVE: state_nx = CHECK;
            CHECK: begin
                if (vec_idx != LAST_VEC)       state_nx = DRIVE;
                else if (pass_idx < LAST_PASS) state_nx = DRIVE;
                else                           state_nx = DONE;
            end
            DONE:  if (start) state_nx = DRIVE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            vec_idx  <= 2'd0;
            pass_idx <= 8'd0;
            a_o      <= 1'b0;
            b_o      <= 1'b0;
            err_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            state <= state_nx;
            // done is flopped one cycle behind entry to DONE so it only ever
            // reports the settled count from the final CHECK edge
            done_q <= (state == DONE) && (state_nx == DONE);

            case (state)
                IDLE, DONE: begin
                    a_o <= 1'b0;
                    b_o <= 1'b0;
                    if (start) begin
                        vec_idx  <= 2'd0;
                        pass_idx <= 8'd0;
                        err_cnt  <= '0;
                    end
                end
                DRIVE: {a_o, b_o} <= vec_idx;
                CHECK: begin
                    if (mismatch && (err_cnt != ERR_MAX))
                        err_cnt <= err_cnt + 1'b1;
                    if (vec_idx != LAST_VEC) begin
                        vec_idx <= vec_idx + 2'd1;
                    end else if (pass_idx < LAST_PASS) begin
                        vec_idx  <= 2'd0;
                        pass_idx <= pass_idx + 8'd1;
                    end else begin
                        a_o <= 1'b0;
                        b_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DEMORGAN_CHK_CAPTURE_EN
    logic [1:0] fail_vec_q;
    logic       fail_valid_q;

    // first mismatch of a run wins; later ones are ignored until restart
    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            fail_vec_q   <= 2'b00;
            fail_valid_q <= 1'b0;
        end else if (mismatch && !fail_valid_q) begin
            fail_vec_q   <= {a_o, b_o};
            fail_valid_q <= 1'b1;
        end
    end

    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;
`else
    assign fail_vec   = 2'b00;
    assign fail_valid = 1'b0;
`endif

    assign busy = (state == DRIVE) || (state == CHECK);
    assign done = done_q;
    assign pass = done_q && (err_cnt == '0);

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// tb/tb_demorgan_sweep_checker.sv - directed self-checking bench for demorgan_sweep_checker

module tb_demorgan_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_w [3];
    logic       dut_c_w [3];
    logic       a_w     [3];
    logic       b_w     [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       pass_w  [3];
    logic [1:0] fvec_w  [3];
    logic       fval_w  [3];
    int         mode    [3];
    int         err_w   [3];

    logic [7:0] err0;
    logic [7:0] err1;
    logic [1:0] err2;

    int chk_count = 0;
    int err_count = 0;
    int vec_obs [4];

    always #5 clk = ~clk;

    demorgan_sweep_checker #(.PASSES(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .dut_c(dut_c_w[0]),
        .a_o(a_w[0]), .b_o(b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .err_cnt(err0), .fail_vec(fvec_w[0]), .fail_valid(fval_w[0]));

    demorgan_sweep_checker #(.PASSES(2), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .dut_c(dut_c_w[1]),
        .a_o(a_w[1]), .b_o(b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .err_cnt(err1), .fail_vec(fvec_w[1]), .fail_valid(fval_w[1]));

    demorgan_sweep_checker #(.PASSES(3), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .dut_c(dut_c_w[2]),
        .a_o(a_w[2]), .b_o(b_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .err_cnt(err2), .fail_vec(fvec_w[2]), .fail_valid(fval_w[2]));

    assign err_w[0] = int'(err0);
    assign err_w[1] = int'(err1);
    assign err_w[2] = int'(err2);

    // Stage models: 0 correct NOR, 1 stuck-at-0, 2 ~a&b, 3 OR
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            case (mode[i])
                0:       dut_c_w[i] = ~(a_w[i] | b_w[i]);
                1:       dut_c_w[i] = 1'b0;
                2:       dut_c_w[i] = ~a_w[i] & b_w[i];
                default: dut_c_w[i] = a_w[i] | b_w[i];
            endcase
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        chk_count++;
        if (obs != exp) begin
            err_count++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulses start on instance i, records the first-pass vectors and returns
    // the number of edges from the start-sampling edge until done is seen.
    task automatic run(input int i, input int extra_start_at, output int cycles);
        start_w[i] = 1'b1;
        @(posedge clk); #1;
        start_w[i] = 1'b0;
        cycles = 0;
        while (!done_w[i] && cycles < 200) begin
            if (cycles == 1 || cycles == 3 || cycles == 5 || cycles == 7)
                vec_obs[cycles / 2] = int'({a_w[i], b_w[i]});
            start_w[i] = (cycles == extra_start_at);
            @(posedge clk); #1;
            cycles++;
        end
        start_w[i] = 1'b0;
    endtask

    task automatic check_fail_capture(input string tag, input int i, input int exp_vec);
`ifdef DEMORGAN_CHK_CAPTURE_EN
        check({tag, "_fvec"}, int'(fvec_w[i]), exp_vec);
        check({tag, "_fval"}, int'(fval_w[i]), 1);
`else
        check({tag, "_fvec"}, int'(fvec_w[i]), 0);
        check({tag, "_fval"}, int'(fval_w[i]), 0 * exp_vec);
`endif
    endtask

    int cyc;

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_w[i] = 1'b0;
            mode[i]    = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", int'(busy_w[i]), 0);
            check("rst_done", int'(done_w[i]), 0);
            check("rst_pass", int'(pass_w[i]), 0);
            check("rst_err",  err_w[i], 0);
            check("rst_ab",   int'({a_w[i], b_w[i]}), 0);
            check("rst_fval", int'(fval_w[i]), 0);
        end

        // correct NOR, one pass
        mode[0] = 0;
        run(0, -1, cyc);
        check("nor_cycles", cyc, 9);
        check("nor_v0", vec_obs[0], 0);
        check("nor_v1", vec_obs[1], 1);
        check("nor_v2", vec_obs[2], 2);
        check("nor_v3", vec_obs[3], 3);
        check("nor_pass", int'(pass_w[0]), 1);
        check("nor_err", err_w[0], 0);
        check("nor_fval", int'(fval_w[0]), 0);
        check("nor_busy", int'(busy_w[0]), 0);
        check("nor_ab", int'({a_w[0], b_w[0]}), 0);

        // stuck-at-0, two passes: vector 00 fails in each pass
        mode[1] = 1;
        run(1, -1, cyc);
        check("sa0_cycles", cyc, 17);
        check("sa0_err", err_w[1], 2);
        check("sa0_pass", int'(pass_w[1]), 0);
        check_fail_capture("sa0", 1, 0);

        // ~a&b stage: mismatches at 00 and 01, first one kept
        mode[0] = 2;
        run(0, -1, cyc);
        check("anb_cycles", cyc, 9);
        check("anb_err", err_w[0], 2);
        check("anb_pass", int'(pass_w[0]), 0);
        check_fail_capture("anb", 0, 0);

        // inverted stage, 3 passes, 2-bit counter: 12 mismatches saturate at 3
        mode[2] = 3;
        run(2, -1, cyc);
        check("sat_cycles", cyc, 25);
        check("sat_err", err_w[2], 3);
        check("sat_pass", int'(pass_w[2]), 0);
        check_fail_capture("sat", 2, 0);

        // reset while vector 10 is being checked
        mode[0] = 2;
        start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("mid_ab_before", int'({a_w[0], b_w[0]}), 2);
        check("mid_busy_before", int'(busy_w[0]), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_busy", int'(busy_w[0]), 0);
        check("mid_done", int'(done_w[0]), 0);
        check("mid_pass", int'(pass_w[0]), 0);
        check("mid_err",  err_w[0], 0);
        check("mid_ab",   int'({a_w[0], b_w[0]}), 0);
        check("mid_fvec", int'(fvec_w[0]), 0);
        check("mid_fval", int'(fval_w[0]), 0);
        mode[0] = 0;
        run(0, -1, cyc);
        check("post_rst_cycles", cyc, 9);
        check("post_rst_err", err_w[0], 0);
        check("post_rst_pass", int'(pass_w[0]), 1);

        // start while busy is ignored; start in DONE clears and reruns
        mode[0] = 3;
        run(0, 3, cyc);
        check("busy_start_cycles", cyc, 9);
        check("busy_start_err", err_w[0], 4);
        check("busy_start_pass", int'(pass_w[0]), 0);
        mode[0] = 0;
        run(0, -1, cyc);
        check("rerun_cycles", cyc, 9);
        check("rerun_err", err_w[0], 0);
        check("rerun_pass", int'(pass_w[0]), 1);
        check("rerun_fval", int'(fval_w[0]), 0);

        $display("CHECKS %0d ERRORS %0d", chk_count, err_count);
        $finish;
    end

endmodule

// File: doc/demorgan_sweep_checker.md
DEMORGAN_SWEEP_CHECKER -- requirements
Module: demorgan_sweep_checker

Interface
REQ-001 Parameter PASSES, default 1, meaning the number of full 4-vector sweeps per run (legal range 1..255).
REQ-002 Parameter CNT_W, default 8, meaning the width of the mismatch counter.
REQ-003 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, single-cycle run request.
REQ-006 Port dut_c, input, 1, the two-input De Morgan NOR stage's output c, driven by the a_o/b_o stimulus.
REQ-007 Port a_o, output, 1, stimulus to the DUT's a input.
REQ-008 Port b_o, output, 1, stimulus to the DUT's b input.
REQ-009 Port busy, output, 1, high while a run is in progress.
REQ-010 Port done, output, 1, high while results are held after a run.
REQ-011 Port pass, output, 1, high with done when err_cnt == 0.
REQ-012 Port err_cnt, output, CNT_W, the mismatch count for the current or last run.
REQ-013 Port fail_vec, output, 2, first failing {a,b}; exists only as described in Configuration.
REQ-014 Port fail_valid, output, 1, fail_vec holds a captured vector.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, CHECK and DONE, encoded as a 2-bit state.
REQ-016 IDLE: a_o=b_o=0, busy=0, done=0; start=1 -> DRIVE, with vector index 0, pass index 0, err_cnt and fail_valid cleared.
REQ-017 DRIVE: {a_o,b_o} = vector index (00,01,10,11 in order), registered; next state is always CHECK.
REQ-018 CHECK: {a_o,b_o} held; expected = ~(a_o | b_o); if dut_c != expected, err_cnt increments.
REQ-019 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 CHECK exit: if vector index < 3 -> increment index, go to DRIVE; if index == 3 and pass index < PASSES-1 -> index 0, pass index +1, go to DRIVE; otherwise -> DONE.
REQ-021 Each vector SHALL take exactly 2 cycles; done SHALL assert 8*PASSES+1 cycles after the edge sampling start.
REQ-022 DONE: done=1, busy=0, pass=(err_cnt==0), a_o=b_o=0; err_cnt and fail_* held; start=1 -> behaves as in IDLE, starting a new run with cleared results.
REQ-023 busy SHALL be 1 exactly in DRIVE and CHECK.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 pass SHALL be 0 whenever done=0.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE with a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_valid=0.
REQ-027 Reset SHALL take priority over start and SHALL abort a run mid-sweep with no partial result retained.

Configuration
REQ-028 With macro DEMORGAN_CHK_CAPTURE_EN defined, the first mismatching {a_o,b_o} of a run SHALL load fail_vec and set fail_valid; later mismatches SHALL NOT overwrite it until the next start or reset.
REQ-029 Without DEMORGAN_CHK_CAPTURE_EN, fail_vec SHALL be tied 2'b00, fail_valid SHALL be tied 0, and no capture registers SHALL be inferred.

Structure
REQ-030 State encoding localparams (IDLE=0, DRIVE=1, CHECK=2, DONE=3) and the vector count constant (4) SHALL live in a shared package demorgan_pkg.
REQ-031 The design SHALL be a single module with no sub-module, and the expected-value computation SHALL be inline.

Verification
REQ-032 Correct NOR DUT, PASSES=1, start pulse -> vectors 00,01,10,11 on a_o/b_o, done at cycle 9, pass=1, err_cnt=0, fail_valid=0.
REQ-033 DUT stuck-at-0 on c, PASSES=2 -> err_cnt=2 (vector 00 in each pass), pass=0, with capture enabled fail_vec=2'b00 and fail_valid=1.
REQ-034 DUT with dut_c = ~a & b, PASSES=1 -> mismatches at 00 and 01, err_cnt=2, fail_vec=2'b00 (first failure kept).
REQ-035 CNT_W=2, DUT inverted (dut_c = a | b), PASSES=3 -> 12 mismatches; err_cnt saturates at 3.
REQ-036 rst asserted during vector 10 of a run -> next cycle in IDLE with all outputs 0; a subsequent start runs a clean full sweep.
REQ-037 start pulsed while busy, then pulsed again in DONE -> the first extra pulse has no effect; the second clears the results and the repeated run yields an identical done timing.
